lc3_mem_responder: RTL and testbench

- Memory-side responder for the LC3 processor's load/store path. Takes single-word read/write requests from the processor control/datapath and answers them.
- Word-addressed 16-bit storage with a configurable number of wait states and a valid/ready handshake on both the request and response channels.
- Replaces the zero-latency memory, so the controller can be verified against slow memory.
- A combinational debug read port is included for testbench inspection.

---
 rtl/lc3_mem_responder.sv | 143 ++++++++++++++
 tb/tb_lc3_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
// LC3 load/store memory responder: word-addressed 16-bit storage behind a
// valid/ready request channel and a valid/ready response channel, with a
// configurable number of wait states between accept and access.
module lc3_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [15:0] dbg_addr,
  output logic [15:0] dbg_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] rdata_q;
  logic        err_q;

  logic [15:0] mem [DEPTH];

  logic        accept;
  logic        access;
  logic        acc_we;
  logic [15:0] acc_addr, acc_wdata;
  logic        acc_in_range;
  logic        dbg_in_range;

  // With zero wait states the access happens on the accepting edge itself, so
  // the live request fields stand in for the not-yet-latched ones.
  always_comb begin
    acc_we       = we_q;
    acc_addr     = addr_q;
    acc_wdata    = wdata_q;
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_in_range = ({16'h0, acc_addr} < DEPTH);
  end

  // Next-state logic: IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, latched request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      rdata_q <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        if (acc_in_range) begin
          rdata_q <= acc_we ? acc_wdata : mem[acc_addr[AW-1:0]];
          err_q   <= 1'b0;
        end else begin
          rdata_q <= 16'h0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && access && acc_we && acc_in_range) begin
      mem[acc_addr[AW-1:0]] <= acc_wdata;
    end
  end

  // Handshake outputs, forced quiet while reset is asserted.
  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
    rsp_valid = (state_q == StResp) && !rst;
    rsp_rdata = rst ? 16'h0 : rdata_q;
    rsp_err   = rst ? 1'b0 : err_q;
  end

  // Asynchronous debug read, no write bypass.
  always_comb begin
    dbg_in_range = ({16'h0, dbg_addr} < DEPTH);
    dbg_data     = 16'h0;
    if (dbg_in_range) dbg_data = mem[dbg_addr[AW-1:0]];
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: instance 0 uses LATENCY=2, instance
// 1 uses LATENCY=0. The driver pushes expected responses on accept; a monitor
// pops and compares on every response handshake, including rise latency.
module tb_lc3_mem_responder;

  localparam int unsigned Lat0 = 2;
  localparam int unsigned Lat1 = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [15:0] dbg_addr  [2];
  logic [15:0] dbg_data  [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc [2];
  int   rise_cyc [2];
  logic prev_v [2];
  logic [15:0] snap [256];

  lc3_mem_responder #(.DEPTH(256), .LATENCY(Lat0)) dut (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
  );

  lc3_mem_responder #(.DEPTH(256), .LATENCY(Lat1)) dut_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] r, input logic e, input int c);
    exp_t x;
    x.rdata = r;
    x.err = e;
    x.acc_cyc = c;
    if (d == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  // Monitor: compare every response handshake against the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1 && prev_v[d] !== 1'b1) rise_cyc[d] = cyc;
      prev_v[d] = rsp_valid[d];
      if (rsp_valid[d] === 1'b1 && rsp_ready[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got rdata %0h with no response expected",
                   d, rsp_rdata[d]);
        end else begin
          exp_t e;
          int lat;
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          lat = (d == 0) ? int'(Lat0) : int'(Lat1);
          chk($sformatf("rsp_rdata dut%0d", d), 32'(rsp_rdata[d]), 32'(e.rdata));
          chk($sformatf("rsp_err dut%0d", d), 32'(rsp_err[d]), 32'(e.err));
          chk($sformatf("rsp_latency dut%0d", d), 32'(rise_cyc[d] - e.acc_cyc), 32'(lat + 1));
        end
      end
    end
  end

  // Present one request, wait (bounded) for accept, optionally expect a response.
  task automatic issue(input int d, input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] er, input logic ee, input bit push);
    bit ok;
    @(posedge clk); #1;
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_addr[d] = a;
    req_wdata[d] = wd;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[d] === 1'b1) begin
        ok = 1'b1;
        acc_cyc[d] = cyc;
        if (push) push_exp(d, er, ee, cyc);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got no req_ready required accept", d);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[d] === 1'b1 && rsp_valid[d] === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout dut%0d: got busy required idle", d);
    end
  endtask

  task automatic snapshot();
    for (int i = 0; i < 256; i++) begin
      dbg_addr[0] = 16'(i);
      #1 snap[i] = dbg_data[0];
    end
  endtask

  task automatic compare_snapshot();
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      dbg_addr[0] = 16'(i);
      #1 if (dbg_data[0] !== snap[i]) diffs++;
    end
    chk("oob_write_changed_locations", 32'(diffs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int a1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d] = 1'b0;
      req_addr[d] = 16'h0;
      req_wdata[d] = 16'h0;
      rsp_ready[d] = 1'b1;
      dbg_addr[d] = 16'h0;
      prev_v[d] = 1'b0;
    end

    // 1. Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("rst rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("post_rst req_ready", 32'(req_ready[0]), 32'd1);

    // 2. Write then read, with debug visibility of the commit edge
    issue(0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_idle(0);
    dbg_addr[0] = 16'h0010;
    issue(0, 1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
    @(negedge clk);
    chk("dbg before commit (wait1)", 32'(dbg_data[0]), 32'h0000);
    @(negedge clk);
    chk("dbg before commit (wait2)", 32'(dbg_data[0]), 32'h0000);
    @(negedge clk);
    chk("dbg after commit", 32'(dbg_data[0]), 32'hBEEF);
    chk("rsp_valid in resp", 32'(rsp_valid[0]), 32'd1);
    wait_idle(0);
    issue(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    wait_idle(0);

    // 3. Out-of-range read and write
    issue(0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_idle(0);
    snapshot();
    issue(0, 1'b1, 16'h0100, 16'hAAAA, 16'h0000, 1'b1, 1'b1);
    wait_idle(0);
    compare_snapshot();
    dbg_addr[0] = 16'h0100;
    #1 chk("dbg oob reads 0", 32'(dbg_data[0]), 32'h0000);

    // 4. Back-pressure: response held, second request refused
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) ok = 1'b1;
    end
    chk("bp rsp_valid seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[0] = 16'h0010;
    req_wdata[0] = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp_valid held", 32'(rsp_valid[0]), 32'd1);
      chk("bp rsp_rdata stable", 32'(rsp_rdata[0]), 32'hBEEF);
      chk("bp req_ready low", 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp req_ready after handshake", 32'(req_ready[0]), 32'd1);
    dbg_addr[0] = 16'h0010;
    #1 chk("bp second req not accepted", 32'(dbg_data[0]), 32'hBEEF);

    // 5. LATENCY=0 instance: preload then back-to-back reads
    issue(1, 1'b1, 16'h0001, 16'h1111, 16'h1111, 1'b0, 1'b1);
    wait_idle(1);
    issue(1, 1'b1, 16'h0002, 16'h2222, 16'h2222, 1'b0, 1'b1);
    wait_idle(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_we[1] = 1'b0;
    a1 = 0;
    for (int k = 1; k <= 2; k++) begin
      req_addr[1] = 16'(k);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (req_ready[1] === 1'b1) begin
          ok = 1'b1;
          push_exp(1, (k == 1) ? 16'h1111 : 16'h2222, 1'b0, cyc);
          if (k == 1) a1 = cyc;
          else chk("lat0 request period", 32'(cyc - a1), 32'd2);
        end
      end
      chk($sformatf("lat0 accept %0d", k), 32'(ok), 32'd1);
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    wait_idle(1);

    // 6. Reset during the second WAIT cycle aborts a write
    issue(0, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_idle(0);
    dbg_addr[0] = 16'h0020;
    issue(0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no rsp_valid", 32'(rsp_valid[0]), 32'd0);
    end
    chk("abort write not committed", 32'(dbg_data[0]), 32'h0000);
    issue(0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b1);
    wait_idle(0);

    repeat (2) @(negedge clk);
    chk("scoreboard0 drained", 32'(q0.size()), 32'd0);
    chk("scoreboard1 drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
